// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared RV-M op codes, FSM encodings and handshake constants for the multiply/divide unit.
package muldiv_unit_pkg;
  typedef logic [2:0] md_op_t;
  localparam md_op_t MD_MUL    = 3'b000;
  localparam md_op_t MD_MULH   = 3'b001;
  localparam md_op_t MD_MULHSU = 3'b010;
  localparam md_op_t MD_MULHU  = 3'b011;
  localparam md_op_t MD_DIV    = 3'b100;
  localparam md_op_t MD_DIVU   = 3'b101;
  localparam md_op_t MD_REM    = 3'b110;
  localparam md_op_t MD_REMU   = 3'b111;
  localparam logic [1:0] MdIdle = 2'b00;
  localparam logic [1:0] MdCalc = 2'b01;
  localparam logic [1:0] MdFix  = 2'b10;
  localparam logic [1:0] MdDone = 2'b11;
  localparam logic RstEnable         = 1'b1;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  typedef enum logic {STEP_MUL, STEP_DIV} step_mode_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration, shift-add multiply or restoring divide on a {hi, lo} accumulator.
module muldiv_step
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  step_mode_e        mode,
  output logic [2*XLEN-1:0] acc_next
);
  logic [XLEN:0] sum;
  logic [XLEN:0] trial;
  always_comb begin
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? operand : {XLEN{1'b0}})};
    // trial subtract uses the bit about to be shifted out so the remainder never overflows
    trial = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
    acc_next = mode == STEP_DIV
      ? (trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0} : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1})
      : {sum, acc[XLEN-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV-M multiply/divide with start/ready handshake beside EX.
// MULDIV_FAST_MUL_EN selects a single-cycle combinational multiplier for the four multiply ops.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            annul_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] opdata1_i,
  input  logic [XLEN-1:0] opdata2_i,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o,
  output logic            busy_o
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  logic [1:0]        state;
  md_op_t            op;
  logic              neg_res;
  logic              neg_rem;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   opnd;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   result;
  step_mode_e        mode;
  logic              is_div, s1, s2, a_neg, b_neg, div0, ovf, early;
  logic [XLEN-1:0]   a_mag, b_mag, early_res, fix_res, q, r;
  logic [2*XLEN-1:0] fix_wide;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] prod;
`endif
  always_comb begin
    is_div = op_i[2];
    s1 = is_div ? !op_i[0] : (op_i == MD_MULH || op_i == MD_MULHSU);
    s2 = is_div ? !op_i[0] : (op_i == MD_MULH);
    a_neg = s1 & opdata1_i[XLEN-1];
    b_neg = s2 & opdata2_i[XLEN-1];
    a_mag = a_neg ? -opdata1_i : opdata1_i;
    b_mag = b_neg ? -opdata2_i : opdata2_i;
    div0 = is_div && opdata2_i == '0;
    ovf = is_div && !op_i[0] && opdata1_i == {1'b1, {(XLEN-1){1'b0}}} && opdata2_i == '1;
`ifdef MULDIV_FAST_MUL_EN
    prod = {{XLEN{a_neg}}, opdata1_i} * {{XLEN{b_neg}}, opdata2_i};
    early = div0 | ovf | !is_div;
    early_res = div0 ? (op_i[1] ? opdata1_i : '1)
              : ovf ? (op_i[1] ? '0 : opdata1_i)
              : (op_i == MD_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
`else
    early = div0 | ovf;
    early_res = div0 ? (op_i[1] ? opdata1_i : '1) : (op_i[1] ? '0 : opdata1_i);
`endif
    fix_wide = neg_res ? -acc : acc;
    q = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    r = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fix_res = !op[2] ? (op == MD_MUL ? fix_wide[XLEN-1:0] : fix_wide[2*XLEN-1:XLEN])
                     : (op[1] ? r : q);
    mode = op[2] ? STEP_DIV : STEP_MUL;
  end
  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc      (acc),
    .operand  (opnd),
    .mode     (mode),
    .acc_next (acc_next)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state   <= MdIdle;
      op      <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      acc     <= '0;
      opnd    <= '0;
      cnt     <= '0;
      result  <= '0;
    end else if (annul_i) begin
      state  <= MdIdle;
      result <= '0;
    end else begin
      case (state)
        MdIdle: if (start_i) begin
          op <= op_i;
          if (early) begin
            result <= early_res;
            state  <= MdDone;
          end else begin
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            acc     <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            opnd    <= is_div ? b_mag : a_mag;
            cnt     <= '0;
            state   <= MdCalc;
          end
        end
        MdCalc: begin
          acc <= acc_next;
          cnt <= cnt == LAST ? cnt : cnt + 1'b1;
          if (cnt == LAST) state <= MdFix;
        end
        MdFix: begin
          result <= fix_res;
          state  <= MdDone;
        end
        MdDone: if (!start_i) state <= MdIdle;
        default: state <= MdIdle;
      endcase
    end
  end
  assign result_o = result;
  assign ready_o  = state == MdDone ? DivResultReady : DivResultNotReady;
  assign busy_o   = state == MdCalc || state == MdFix;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (XLEN=32), latency aware of MULDIV_FAST_MUL_EN.
module tb_muldiv_unit;
  logic        clk = 0;
  logic        rst = 1;
  logic        start_i = 0;
  logic        annul_i = 0;
  logic [2:0]  op_i = 0;
  logic [31:0] opdata1_i = 0;
  logic [31:0] opdata2_i = 0;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;
  int errors = 0;
  int checks = 0;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 34;
`endif
  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .op_i      (op_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc = 0;
    logic busy_seen = 0;
    @(negedge clk);
    op_i = op; opdata1_i = a; opdata2_i = b; start_i = 1;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin op_i = ~op; opdata1_i = ~a; opdata2_i = ~b; end
      busy_seen |= busy_o;
      if (ready_o) break;
    end
    chk({tag, " result"}, result_o, exp);
    chk({tag, " latency"}, cyc, lat);
    chk({tag, " busy"}, 32'(busy_seen), 32'(lat != 1));
    @(negedge clk);
    start_i = 0;
    @(posedge clk); #1;
    chk({tag, " ready drop"}, 32'(ready_o), 32'd0);
  endtask
  initial begin
    int ready_seen;
    #12;
    chk("reset ready", 32'(ready_o), 32'd0);
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset result", result_o, 32'd0);
    @(negedge clk);
    rst = 0;
    do_op("divu 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 34);
    do_op("remu 100/7", 3'b111, 32'd100, 32'd7, 32'd2, 34);
    do_op("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    do_op("rem -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    do_op("div 7/-2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    do_op("rem 7/-2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    do_op("div 5/0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("remu 5/0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
    do_op("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    do_op("mul -1*-1", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, MLAT);
    do_op("mulh -1*-1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, MLAT);
    do_op("mulhu max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MLAT);
    do_op("mulhsu -1*max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MLAT);
    do_op("mulh min*2", 3'b001, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, MLAT);
    // flush a divide in cycle 10
    @(negedge clk);
    op_i = 3'b100; opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1;
    for (int i = 1; i <= 10; i++) @(posedge clk);
    @(negedge clk);
    annul_i = 1; start_i = 0;
    @(posedge clk); #1;
    chk("annul busy", 32'(busy_o), 32'd0);
    chk("annul ready", 32'(ready_o), 32'd0);
    chk("annul result", result_o, 32'd0);
    @(negedge clk);
    annul_i = 0;
    ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      ready_seen |= int'(ready_o);
    end
    chk("annul no ready", 32'(ready_seen), 32'd0);
    do_op("divu 9/3", 3'b101, 32'd9, 32'd3, 32'd3, 34);
    // async reset in cycle 20 of a MULHU
    @(negedge clk);
    op_i = 3'b011; opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'hFFFF_FFFF; start_i = 1;
    for (int i = 1; i <= 20; i++) @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("rst ready", 32'(ready_o), 32'd0);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst result", result_o, 32'd0);
    start_i = 0;
    @(negedge clk);
    rst = 0;
    do_op("mulhu 3*4", 3'b011, 32'd3, 32'd4, 32'd0, MLAT);
    do_op("mul 3*4", 3'b000, 32'd3, 32'd4, 32'd12, MLAT);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
